// File: rtl/regwrite_seq.sv
// Issue/writeback sequencer for the 16x16 register file: decodes one instruction,
// waits ALU_LAT cycles, then pulses a one-hot register write enable.
module regwrite_seq #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [3:0]  a_sel,
    output logic [3:0]  b_sel,
    output logic        use_imm,
    output logic [15:0] imm,
    output logic [3:0]  alu_op,
    output logic [15:0] reg_en,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StDecode, StExec, StWb} state_t;

    localparam logic [3:0] OpCmp   = 4'hB;
    localparam logic [3:0] LastCnt = 4'(ALU_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  a_sel_q, b_sel_q, alu_op_q;
    logic        use_imm_q;
    logic [15:0] imm_q;
    logic [15:0] reg_en_q, reg_en_d;
    logic        done_q, done_d;
    logic        accept;
    logic        exec_last;

    assign accept    = instr_valid && (state_q == StIdle);
    assign exec_last = (state_q == StExec) && (cnt_q == LastCnt);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (instr_valid) state_d = StDecode;
            StDecode: state_d = StExec;
            StExec:   if (cnt_q == LastCnt) state_d = StExec == StExec ? StWb : StExec;
            StWb:     state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        instr_ready = (state_q == StIdle);
        cnt_d       = (state_q == StExec) ? cnt_q + 4'd1 : 4'd0;
        reg_en_d    = 16'h0000;
        done_d      = 1'b0;
        if (exec_last) begin
            done_d = 1'b1;
            if (alu_op_q != OpCmp) begin
                reg_en_d = 16'h0001 << a_sel_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= 4'd0;
            reg_en_q  <= 16'h0000;
            done_q    <= 1'b0;
            a_sel_q   <= 4'd0;
            b_sel_q   <= 4'd0;
            alu_op_q  <= 4'd0;
            use_imm_q <= 1'b0;
            imm_q     <= 16'h0000;
        end else begin
            cnt_q    <= cnt_d;
            reg_en_q <= reg_en_d;
            done_q   <= done_d;
            if (accept) begin
                a_sel_q <= instr[11:8];
                if (instr[15:12] == 4'h0) begin
                    alu_op_q  <= instr[7:4];
                    use_imm_q <= 1'b0;
                    b_sel_q   <= instr[3:0];
                    imm_q     <= 16'h0000;
                end else begin
                    alu_op_q  <= instr[15:12];
                    use_imm_q <= 1'b1;
                    b_sel_q   <= 4'd0;
                    imm_q     <= {{8{instr[7]}}, instr[7:0]};
                end
            end
        end
    end

    assign a_sel   = a_sel_q;
    assign b_sel   = b_sel_q;
    assign use_imm = use_imm_q;
    assign imm     = imm_q;
    assign alu_op  = alu_op_q;
    // Reset during WB must suppress the pulse, so the registered strobes are masked here.
    assign reg_en  = reg_en_q & {16{~reset}};
    assign done    = done_q & ~reset;

endmodule

// File: doc/regwrite_seq.md
# regwrite_seq

Issue/writeback sequencer that sits directly upstream of the 16×16 register file. It accepts one 16-bit instruction at a time over a valid/ready handshake and decodes register selects, ALU opcode and immediate for the operand muxes and ALU. It waits a fixed ALU latency, then drives the register file's one-hot 16-bit write-enable vector for exactly one cycle so the ALU bus result is captured.

## Interface
Parameters:
- ALU_LAT, 1, cycles from operands-valid to ALU bus result stable; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- instr  in  16  instruction word; sampled only on the accept cycle.
- instr_valid  in  1  upstream has an instruction on instr.
- instr_ready  out  1  block is in IDLE and can accept.
- a_sel  out  4  register index for ALU operand A (Rdest).
- b_sel  out  4  register index for ALU operand B (Rsrc).
- use_imm  out  1  1 = operand B comes from imm, not b_sel.
- imm  out  16  sign-extended 8-bit immediate.
- alu_op  out  4  ALU operation code.
- reg_en  out  16  one-hot write enable to the register file; bit i writes register i.
- done  out  1  one-cycle pulse in the WB cycle, including no-write ops.

## Operation
- Field decode: op = instr[15:12], rdest = instr[11:8], ext = instr[7:4], rsrc = instr[3:0].
- Register form (op == 4'h0): alu_op = ext, use_imm = 0, b_sel = rsrc, imm = 0.
- Immediate form (op != 4'h0): alu_op = op, use_imm = 1, imm = sign-extend of instr[7:0], b_sel = 0.
- a_sel = rdest in both forms.
- No-writeback op: final alu_op == 4'hB (compare). The block still sequences fully and pulses done, but reg_en stays 0.
- Writes to any register index 0..15 are legal, including r0.
- FSM states:
  - IDLE: instr_ready = 1. On instr_valid, capture the decoded fields and go to DECODE.
  - DECODE: one cycle; decoded outputs are valid. Go to EXEC.
  - EXEC: counter counts ALU_LAT cycles. Go to WB when count reaches ALU_LAT−1.
  - WB: one cycle; reg_en = 1 << rdest (or 0 for a no-write op); done = 1. Go to IDLE.
- a_sel, b_sel, use_imm, imm and alu_op are registered. They hold stable from DECODE through WB and keep their values in IDLE until the next accept.
- reg_en is registered and is 0 in every state except WB. At most one bit is ever set.

## Timing
- Reset values:
  - state = IDLE, counter = 0.
  - reg_en = 0, done = 0, a_sel = 0, b_sel = 0, use_imm = 0, imm = 0, alu_op = 0.
- Reset has priority. An instruction presented while reset = 1 is not accepted, even though instr_ready = 1.
- instr_ready = (state == IDLE) combinationally. Accept = instr_valid & instr_ready at a rising edge.
- Accept at edge T gives:
  - DECODE in cycle T+1.
  - EXEC in cycles T+2 .. T+1+ALU_LAT.
  - WB in cycle T+2+ALU_LAT; the register file captures on the edge that ends WB.
  - instr_ready high again in cycle T+3+ALU_LAT.
- Throughput: one instruction per ALU_LAT+3 cycles.
- instr may change freely when not accepted. instr_valid held high in non-IDLE states is ignored (no queuing).
- Reset asserted mid-operation: the next edge forces IDLE. No reg_en or done pulse is produced for the aborted instruction, even if reset arrives in the WB cycle.
- Back-to-back: if instr_valid is high in the first IDLE cycle after WB, that instruction is accepted with zero bubble beyond IDLE.

## Test plan
- Reset: hold reset 3 cycles with instr_valid = 1 and instr = 16'h0152 -> no accept; all outputs 0; instr_ready = 1 in the first cycle after release.
- Register ADD, ALU_LAT = 1: instr = 16'h0352 -> a_sel = 3, b_sel = 2, alu_op = 5, use_imm = 0 from T+1; reg_en = 16'h0008 and done = 1 only in cycle T+3; instr_ready at T+4.
- Immediate, negative value: instr = 16'h5AF0 -> alu_op = 5, a_sel = 10, use_imm = 1, imm = 16'hFFF0; reg_en = 16'h0400 for one cycle.
- Compare and r15 write: instr = 16'h04B1 -> done pulses, reg_en stays 0 in every cycle. Then instr = 16'h3F01 -> reg_en = 16'h8000.
- ALU_LAT = 4 with instr_valid held high continuously -> accepts spaced exactly 7 cycles apart; each WB is 6 cycles after its accept; no extra accepts.
- Reset in the WB cycle of 16'h0752 -> reg_en and done are 0 on that edge and after; the next instruction behaves normally.
